// File: rtl/data_src_pkg.sv
// Shared constants and FSM state type for the increment-benchmark stream blocks.
package data_src_pkg;

    localparam int unsigned DATA_W_DEF = 512;
    localparam int unsigned LANE_W_DEF = 32;
    localparam int unsigned LANES      = DATA_W_DEF / LANE_W_DEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register: loads a beat, holds it under backpressure.
module axis_out_reg #(
    parameter int unsigned DATA_W = 512
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d, data_q;

    // The caller only asserts load_i when the register is empty or handshaking.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/data_src1.sv
// Stream transmitter: emits num_beats beats of incrementing lane values under ap_ctrl_hs control.
module data_src1
    import data_src_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [CNT_W-1:0]  num_beats,
    input  logic [LANE_W-1:0] seed,
    output logic [DATA_W-1:0] Output_1_TDATA,
    output logic              Output_1_TVALID,
    input  logic              Output_1_TREADY
);

    localparam int unsigned       NLANES    = DATA_W / LANE_W;
    localparam logic [LANE_W-1:0] LANE_STEP = LANE_W'(NLANES);

    state_e            state_q;
    logic [CNT_W-1:0]  beats_q;
    logic [CNT_W-1:0]  beat_idx_q;
    logic [LANE_W-1:0] base_q;
    logic              done_q;
    logic              idle_q;

    logic              accept;
    logic              tvalid;
    logic              can_load;
    logic              load;
    logic              last_hs;
    logic [LANE_W-1:0] lane_base;
    logic [DATA_W-1:0] load_data;

    assign accept    = (state_q == S_IDLE) && ap_start;
    assign can_load  = !tvalid || Output_1_TREADY;
    assign load      = (accept && (num_beats != '0))
                     || ((state_q == S_RUN) && can_load && (beat_idx_q != beats_q));
    assign last_hs   = (state_q == S_RUN) && tvalid && Output_1_TREADY
                     && (beat_idx_q == beats_q);
    // Beat 0 is loaded straight from the seed port on the accept edge.
    assign lane_base = (state_q == S_IDLE) ? seed : base_q;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        assign load_data[i*LANE_W +: LANE_W] = lane_base + LANE_W'(i);
    end

    // beat_idx_q counts beats loaded into the output register so far.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            beats_q    <= '0;
            beat_idx_q <= '0;
            base_q     <= '0;
            done_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        beats_q <= num_beats;
                        idle_q  <= 1'b0;
                        if (num_beats == '0) begin
                            beat_idx_q <= '0;
                            base_q     <= seed;
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                        end else begin
                            beat_idx_q <= CNT_W'(1);
                            base_q     <= seed + LANE_STEP;
                            state_q    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (load) begin
                        beat_idx_q <= beat_idx_q + CNT_W'(1);
                        base_q     <= base_q + LANE_STEP;
                    end
                    if (last_hs) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    idle_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    axis_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst_n),
        .load_i (load),
        .data_i (load_data),
        .ready_i(Output_1_TREADY),
        .valid_o(tvalid),
        .data_o (Output_1_TDATA)
    );

    assign Output_1_TVALID = tvalid;
    assign ap_ready        = accept;
    assign ap_done         = done_q;
    assign ap_idle         = idle_q;

endmodule

// File: tb/tb_data_src1.sv
// Randomised self-checking bench for data_src1 against a lane-arithmetic reference model.
`timescale 1ns/1ps
module tb_data_src1;

    localparam int DW = 512;
    localparam int LW = 32;
    localparam int NL = DW / LW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic [31:0]   num_beats = '0;
    logic [LW-1:0] seed = '0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cycle;
    logic [DW-1:0] got_q[$];

    always #5 clk = ~clk;

    data_src1 dut (
        .ap_clk         (clk),
        .ap_rst_n       (rst_n),
        .ap_start       (ap_start),
        .ap_done        (ap_done),
        .ap_idle        (ap_idle),
        .ap_ready       (ap_ready),
        .num_beats      (num_beats),
        .seed           (seed),
        .Output_1_TDATA (tdata),
        .Output_1_TVALID(tvalid),
        .Output_1_TREADY(tready)
    );

    function automatic logic [DW-1:0] exp_beat(input logic [LW-1:0] s, input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*LW +: LW] = s + 32'(k * NL + i);
        return r;
    endfunction

    // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: random ready and stray ap_start
    task automatic test_run(input logic [LW-1:0] s, input int nb, input int mode);
        int       k;
        int       stalls;
        bit       fin;
        bit       prev_stall;
        bit       mvalid;
        logic     exp_done;
        logic [DW-1:0] prev_data;
        got_q.delete();
        k = 0; stalls = 0; fin = 0; prev_stall = 0; done_cycle = -1; prev_data = '0;
        @(negedge clk);
        ap_start = 1'b1; num_beats = 32'(nb); seed = s; tready = 1'b1;
        #1;
        checks += 2;
        if (ap_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b want 1", ap_ready); end
        if (ap_idle !== 1'b1) begin errors++; $display("FAIL accept_idle: got %b want 1", ap_idle); end
        for (int c = 1; c <= 4000 && !fin; c++) begin
            @(negedge clk);
            ap_start  = (mode == 2) ? ($urandom_range(0, 1) != 0) : 1'b0;
            num_beats = $urandom;
            seed      = $urandom;
            case (mode)
                0:       tready = 1'b1;
                1:       tready = ((c - 1) % 3 == 0);
                default: tready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            mvalid   = (k < nb);
            exp_done = (c == nb + 1 + stalls);
            checks += 4;
            if (ap_done !== exp_done) begin
                errors++; $display("FAIL run_done c=%0d: got %b want %b", c, ap_done, exp_done);
            end
            if (ap_ready !== 1'b0) begin errors++; $display("FAIL run_ready c=%0d: got %b want 0", c, ap_ready); end
            if (ap_idle !== 1'b0) begin errors++; $display("FAIL run_idle c=%0d: got %b want 0", c, ap_idle); end
            if (tvalid !== mvalid) begin
                errors++; $display("FAIL run_tvalid c=%0d: got %b want %b", c, tvalid, mvalid);
            end
            if (prev_stall) begin
                checks++;
                if (tdata !== prev_data) begin
                    errors++; $display("FAIL stall_hold c=%0d: got %h want %h", c, tdata, prev_data);
                end
            end
            if (mvalid && tready) begin
                checks++;
                if (tdata !== exp_beat(s, k)) begin
                    errors++; $display("FAIL beat_data k=%0d: got %h want %h", k, tdata, exp_beat(s, k));
                end
                got_q.push_back(tdata);
                k++;
            end
            prev_stall = mvalid && !tready;
            if (prev_stall) stalls++;
            prev_data = tdata;
            if (exp_done || ap_done === 1'b1) begin
                fin = 1; done_cycle = c;
            end
        end
        if (!fin) begin errors++; $display("FAIL run_timeout: got no done want done"); end
        @(negedge clk);
        ap_start = 1'b0;
        #1;
        checks += 3;
        if (ap_idle !== 1'b1) begin errors++; $display("FAIL post_idle: got %b want 1", ap_idle); end
        if (tvalid !== 1'b0) begin errors++; $display("FAIL post_tvalid: got %b want 0", tvalid); end
        if (ap_done !== 1'b0) begin errors++; $display("FAIL post_done: got %b want 0", ap_done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ap_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks += 5;
        if (ap_idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", ap_idle); end
        if (ap_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", ap_done); end
        if (ap_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ap_ready); end
        if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", tvalid); end
        if (tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h want 0", tdata); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks += 2;
        if (ap_idle !== 1'b1) begin errors++; $display("FAIL rst_rel_idle: got %b want 1", ap_idle); end
        if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_rel_tvalid: got %b want 0", tvalid); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] b;
        test_run(32'd0, 4, 0);
        checks += 2;
        if (done_cycle != 5) begin errors++; $display("FAIL basic_done_cycle: got %0d want 5", done_cycle); end
        if (got_q.size() != 4) begin
            errors++; $display("FAIL basic_beats: got %0d want 4", got_q.size());
        end else begin
            b = got_q[3];
            checks++;
            if (b[15*LW +: LW] !== 32'd63) begin
                errors++; $display("FAIL basic_b3_l15: got %0d want 63", b[15*LW +: LW]);
            end
        end
    endtask

    task automatic test_stall();
        test_run(32'd0, 4, 1);
        checks += 2;
        if (done_cycle != 11) begin errors++; $display("FAIL stall_done_cycle: got %0d want 11", done_cycle); end
        if (got_q.size() != 4) begin errors++; $display("FAIL stall_beats: got %0d want 4", got_q.size()); end
    endtask

    task automatic test_zero();
        test_run($urandom, 0, 0);
        checks += 2;
        if (done_cycle != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", done_cycle); end
        if (got_q.size() != 0) begin errors++; $display("FAIL zero_beats: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] b;
        test_run(32'hFFFF_FFF8, 2, 0);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL wrap_beats: got %0d want 2", got_q.size());
        end else begin
            checks += 2;
            b = got_q[0];
            if (b[8*LW +: LW] !== 32'h0) begin
                errors++; $display("FAIL wrap_b0_l8: got %h want 0", b[8*LW +: LW]);
            end
            b = got_q[1];
            if (b[0 +: LW] !== 32'h8) begin
                errors++; $display("FAIL wrap_b1_l0: got %h want 8", b[0 +: LW]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [LW-1:0] s;
        logic [DW-1:0] b;
        s = $urandom;
        @(negedge clk);
        ap_start = 1'b1; num_beats = 32'd10; seed = s; tready = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (tvalid !== 1'b1 || tdata !== exp_beat(s, 2)) begin
            errors++; $display("FAIL mid_beat2: got %b/%h want 1/%h", tvalid, tdata, exp_beat(s, 2));
        end
        #1 rst_n = 1'b0;
        #1;
        checks += 3;
        if (tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b want 0", tvalid); end
        if (ap_idle !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got %b want 1", ap_idle); end
        if (tdata !== '0) begin errors++; $display("FAIL mid_rst_tdata: got %h want 0", tdata); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            #1;
            checks += 2;
            if (ap_done !== 1'b0) begin errors++; $display("FAIL mid_no_done c=%0d: got %b want 0", c, ap_done); end
            if (ap_idle !== 1'b1) begin errors++; $display("FAIL mid_idle c=%0d: got %b want 1", c, ap_idle); end
        end
        test_run(32'd5, 3, 0);
        checks++;
        if (got_q.size() != 3) begin
            errors++; $display("FAIL mid_restart_beats: got %0d want 3", got_q.size());
        end else begin
            b = got_q[0];
            checks++;
            if (b[0 +: LW] !== 32'd5) begin errors++; $display("FAIL mid_restart_l0: got %0d want 5", b[0 +: LW]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] s1;
        logic [LW-1:0] s2;
        int rdy_q[$];
        int done_q[$];
        logic [DW-1:0] beats_q[$];
        s1 = $urandom; s2 = $urandom;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            tready = 1'b1;
            if (c == 0) begin ap_start = 1'b1; num_beats = 32'd3; seed = s1; end
            if (c == 1) seed = s2;
            if (c == 6) ap_start = 1'b0;
            #1;
            if (ap_ready === 1'b1) rdy_q.push_back(c);
            if (ap_done === 1'b1) done_q.push_back(c);
            if (tvalid === 1'b1 && tready) beats_q.push_back(tdata);
        end
        checks += 3;
        if (rdy_q.size() != 2 || rdy_q[0] != 0 || rdy_q[1] != 5) begin
            errors++; $display("FAIL b2b_ready: got %0d pulses (%p) want cycles 0,5", rdy_q.size(), rdy_q);
        end
        if (done_q.size() != 2 || done_q[0] != 4 || done_q[1] != 9) begin
            errors++; $display("FAIL b2b_done: got %0d pulses (%p) want cycles 4,9", done_q.size(), done_q);
        end
        if (beats_q.size() != 6) begin
            errors++; $display("FAIL b2b_beats: got %0d want 6", beats_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (beats_q[k] !== exp_beat((k < 3) ? s1 : s2, k % 3)) begin
                    errors++; $display("FAIL b2b_data k=%0d: got %h want %h", k, beats_q[k],
                                       exp_beat((k < 3) ? s1 : s2, k % 3));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) test_run($urandom, $urandom_range(0, 12), 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_wrap();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_src1.md
# data_src1

Stream transmitter for the increment benchmark: under ap_ctrl_hs-style control it produces a programmed number of 512-bit AXI-Stream beats of incrementing 32-bit lane values. It drives the input stream of the `data_proc` operators, so a bench or a downstream checker can predict every word. One output register provides full throughput under constant `TREADY` and holds data stable under backpressure.

## Interface
- `DATA_W`, 512, stream width; must be a multiple of `LANE_W`.
- `LANE_W`, 32, lane width; `LANES = DATA_W/LANE_W` (16 at defaults).
- `CNT_W`, 32, width of the beat counter and of `num_beats`.

Ports:
- `ap_clk`  in  1  sole clock; every register is rising-edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `ap_start`  in  1  run request; sampled only in IDLE.
- `ap_done`  out  1  one-cycle pulse when the run completes.
- `ap_idle`  out  1  high while in IDLE.
- `ap_ready`  out  1  one-cycle pulse when `ap_start` is accepted.
- `num_beats`  in  CNT_W  beats to send; latched on accept.
- `seed`  in  LANE_W  value of lane 0 of beat 0; latched on accept.
- `Output_1_TDATA`  out  DATA_W  beat data.
- `Output_1_TVALID`  out  1  beat valid.
- `Output_1_TREADY`  in  1  sink ready.

## Operation
- Reset values: `ap_done=0`, `ap_ready=0`, `ap_idle=1`, `TVALID=0`, `TDATA=0`, state IDLE, counters 0.
- FSM states:
  - IDLE: on `ap_start=1`, latch `num_beats` and `seed`, pulse `ap_ready`, clear beat index k.
    - Latched `num_beats==0` -> DONE.
    - Otherwise -> RUN.
  - RUN: load the output register whenever it is empty or handshaking (`!TVALID || TREADY`) and beats remain.
    - After the handshake of beat `num_beats-1` -> DONE.
  - DONE: one cycle; `ap_done=1`, `TVALID=0` -> IDLE.
- Beat k, lane i: `seed + k*LANES + i`, modulo 2^LANE_W (wraps silently). Lane i occupies `TDATA[i*LANE_W +: LANE_W]`.
- AXIS rules:
  - Once `TVALID=1`, `TVALID` and `TDATA` hold unchanged until `TREADY=1`.
  - `TVALID` never depends combinationally on `TREADY`.
  - No bubbles while `TREADY=1`.
- `ap_start` held high: the block restarts from DONE -> IDLE -> accept, giving one idle cycle between runs. `num_beats` and `seed` are re-sampled on each accept.
- `ap_start` outside IDLE is ignored. Changes to `num_beats` or `seed` after accept have no effect.
- Reset mid-run: immediately drop `TVALID`, return to IDLE. No `ap_done` is issued for the aborted run.

## Timing
- Accept in cycle 0 (`ap_ready=1`) -> first `TVALID=1` in cycle 1.
- With `TREADY` constantly 1: beat k handshakes in cycle 1+k. `ap_done` fires in cycle `num_beats+1`, `ap_idle=1` in cycle `num_beats+2`.
- `num_beats==0`: `ap_ready` in cycle 0, `ap_done` in cycle 1, `TVALID` never asserted.
- Each cycle of `TREADY=0` while `TVALID=1` delays `ap_done` by exactly one cycle.
- `ap_idle` is registered: low from cycle 1 of a run until the cycle after `ap_done`.

## Structure
- Shared package `data_src_pkg`:
  - state enum (`S_IDLE`, `S_RUN`, `S_DONE`);
  - `LANES` and the `DATA_W`/`LANE_W` defaults.
  - The `data_proc` operators reuse these constants.
- Sub-module `axis_out_reg`: a one-entry AXIS output register (load/hold/handshake) parameterised by `DATA_W`. `data_src1` instantiates it, and sink-side blocks reuse it.
- The lane-data computation stays inline as a generate loop over `LANES` adders from a base register, `seed + k*LANES`. The base advances by `LANES` per loaded beat, so no multiplier is needed.

## Test plan
- `num_beats=4`, `seed=0`, `TREADY=1` -> beats in cycles 1–4 with lane i of beat k = 16k+i. Beat 3, lane 15 = 63. `ap_done` in cycle 5.
- Same run with `TREADY` toggling 1,0,0,1,... -> identical data sequence, data stable during stalls, `ap_done` delayed by the number of stall cycles.
- `num_beats=0` -> `ap_ready` in cycle 0, `ap_done` in cycle 1, zero beats emitted.
- `seed=0xFFFF_FFF8`, `num_beats=2` -> beat 0, lane 8 = `0x0000_0000`; beat 1, lane 0 = `0x0000_0008`.
- `ap_rst_n` low during beat 2 of 10 -> `TVALID=0` and `ap_idle=1` immediately, no `ap_done`. A new run with `seed=5` restarts at lane 0 = 5.
- `ap_start` held high for two runs of 3 beats -> two `ap_ready` pulses 5 cycles apart, two `ap_done` pulses, 6 beats total.
